// File: rtl/seg7_scan_if.sv
// Display bus for seg7_scan: value/control toward the driver,
// digit enables, segments and scan tick back out.
interface seg7_scan_if;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic        enable;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        tick;

    modport master (
        output value, dp_in, blank_lz, enable,
        input  an, seg, dp, tick
    );

    modport slave (
        input  value, dp_in, blank_lz, enable,
        output an, seg, dp, tick
    );
endinterface

// File: rtl/seg7_scan.sv
// Time-multiplexed 4-digit hex seven-segment driver, common anode,
// active-low outputs, value captured once per refresh frame.
module seg7_scan #(
    parameter int DIV_BITS = 16
) (
    input logic        clk,
    input logic        clr,
    seg7_scan_if.slave bus
);

    logic [DIV_BITS-1:0] pre;
    logic [1:0]          idx;
    logic [15:0]         shadow_val;
    logic [3:0]          shadow_dp;
    logic [3:0]          nib;
    logic [6:0]          glyph;
    logic                blank;

    assign bus.tick = &pre;

    always_comb begin
        nib = shadow_val[{idx, 2'b00} +: 4];
    end

    // Leading-zero test looks only at the more significant nibbles
    always_comb begin
        blank = 1'b0;
        if (bus.blank_lz) begin
            unique case (idx)
                2'd3:    blank = (shadow_val[15:12] == 4'h0);
                2'd2:    blank = (shadow_val[15:8] == 8'h00);
                2'd1:    blank = (shadow_val[15:4] == 12'h000);
                default: blank = 1'b0;
            endcase
        end
    end

    always_comb begin
        glyph = 7'b1111111;
        unique case (nib)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            4'hF: glyph = 7'b0001110;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            pre        <= '0;
            idx        <= 2'd0;
            shadow_val <= 16'h0000;
            shadow_dp  <= 4'b0000;
            bus.an     <= 4'b1111;
            bus.seg    <= 7'b1111111;
            bus.dp     <= 1'b1;
        end else begin
            pre <= pre + 1'b1;
            if (bus.tick) begin
                idx <= idx + 2'd1;
                // Capture only at the frame boundary so a frame never tears
                if (idx == 2'd3) begin
                    shadow_val <= bus.value;
                    shadow_dp  <= bus.dp_in;
                end
            end
            if (bus.enable) begin
                bus.an  <= ~(4'b0001 << idx);
                bus.seg <= blank ? 7'b1111111 : glyph;
                bus.dp  <= ~shadow_dp[idx];
            end else begin
                bus.an  <= 4'b1111;
                bus.seg <= 7'b1111111;
                bus.dp  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan: expected digit slots are queued by
// the stimulus and checked by a monitor at every scan tick.
module tb_seg7_scan;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] SB = 7'b0000011;
    localparam logic [6:0] SC = 7'b1000110;
    localparam logic [6:0] SD = 7'b0100001;
    localparam logic [6:0] SE = 7'b0000110;
    localparam logic [6:0] SF = 7'b0001110;
    localparam logic [6:0] BL = 7'b1111111;

    logic clk = 1'b0;
    logic clr;
    int   total = 0;
    int   bad = 0;
    logic [11:0] exp_q[$];

    seg7_scan_if bus ();

    seg7_scan #(.DIV_BITS(2)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [11:0] got,
                         input logic [11:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Monitor: at each tick the display holds the digit of the current idx
    int  gap = 0;
    bit  have_last = 0;
    always @(negedge clk) begin
        if (!clr) begin
            have_last = 0;
            gap = 0;
        end else begin
            gap++;
            if (bus.tick) begin
                if (have_last)
                    check("tick_gap", 12'(gap), 12'd4);
                have_last = 1;
                gap = 0;
                if (exp_q.size() == 0) begin
                    check("unexpected_slot", {bus.an, bus.seg, bus.dp}, 12'hfff);
                end else begin
                    check("slot", {bus.an, bus.seg, bus.dp}, exp_q.pop_front());
                end
            end
        end
    end

    task automatic slot(input logic [3:0] an, input logic [6:0] seg,
                        input logic dp);
        bit seen = 0;
        exp_q.push_back({an, seg, dp});
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.tick) seen = 1;
        end
        if (!seen) check("tick_timeout", 12'd0, 12'd1);
        @(posedge clk);
        #2;
    endtask

    task automatic frame(input logic [6:0] s0, s1, s2, s3,
                         input logic [3:0] dpl);
        slot(4'b1110, s0, dpl[0]);
        slot(4'b1101, s1, dpl[1]);
        slot(4'b1011, s2, dpl[2]);
        slot(4'b0111, s3, dpl[3]);
    endtask

    initial begin
        clr = 1'b0;
        bus.enable = 1'b1;
        bus.value = 16'h1234;
        bus.dp_in = 4'b0000;
        bus.blank_lz = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_an", {8'h0, bus.an}, 12'h00f);
        check("rst_seg", {5'h0, bus.seg}, 12'h07f);
        check("rst_dp", {11'h0, bus.dp}, 12'h001);
        check("rst_tick", {11'h0, bus.tick}, 12'h000);
        clr = 1'b1;

        frame(S0, S0, S0, S0, 4'hF);
        frame(S4, S3, S2, S1, 4'hF);

        slot(4'b1110, S4, 1'b1);
        bus.value = 16'hABCD;
        slot(4'b1101, S3, 1'b1);
        slot(4'b1011, S2, 1'b1);
        slot(4'b0111, S1, 1'b1);

        bus.blank_lz = 1'b1;
        bus.value = 16'h0050;
        frame(SD, SC, SB, SA, 4'hF);
        bus.value = 16'h0000;
        frame(S0, S5, BL, BL, 4'hF);
        bus.value = 16'h0007;
        bus.dp_in = 4'b0100;
        frame(S0, BL, BL, BL, 4'hF);
        frame(S7, BL, BL, BL, 4'b1011);

        slot(4'b1110, S7, 1'b1);
        bus.enable = 1'b0;
        @(posedge clk);
        #1;
        check("off", {bus.an, bus.seg, bus.dp}, {4'b1111, BL, 1'b1});
        slot(4'b1111, BL, 1'b1);
        bus.enable = 1'b1;
        @(posedge clk);
        #1;
        check("reon", {bus.an, bus.seg, bus.dp}, {4'b1011, BL, 1'b0});
        slot(4'b1011, BL, 1'b0);
        slot(4'b0111, BL, 1'b1);

        bus.blank_lz = 1'b0;
        bus.value = 16'h6E89;
        bus.dp_in = 4'b0000;
        frame(S7, S0, S0, S0, 4'b1011);
        bus.value = 16'hFFFF;
        frame(S9, S8, SE, S6, 4'hF);

        slot(4'b1110, SF, 1'b1);
        slot(4'b1101, SF, 1'b1);
        @(posedge clk);
        #2;
        clr = 1'b0;
        #1;
        check("clr_an", {8'h0, bus.an}, 12'h00f);
        check("clr_seg", {5'h0, bus.seg}, 12'h07f);
        check("clr_dp", {11'h0, bus.dp}, 12'h001);
        check("clr_tick", {11'h0, bus.tick}, 12'h000);
        repeat (2) @(negedge clk);
        clr = 1'b1;
        frame(S0, S0, S0, S0, 4'hF);
        frame(SF, SF, SF, SF, 4'hF);

        check("queue_empty", 12'(exp_q.size()), 12'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
